// File: rtl/stroke_drawer_pkg.sv
// Shared constants and types for the lightboard drawing path: frame and canvas
// geometry, pixel colour type and the stroke drawer state encoding.
package lightboard_pkg;

  localparam int H_PIXELS      = 1280;
  localparam int V_PIXELS      = 720;
  localparam int CANVAS_SHIFT  = 2;
  localparam int CANVAS_W      = H_PIXELS >> CANVAS_SHIFT;
  localparam int CANVAS_H      = V_PIXELS >> CANVAS_SHIFT;
  localparam int CANVAS_PIXELS = CANVAS_W * CANVAS_H;

  typedef logic [1:0]  colour_t;
  typedef logic [8:0]  cx_t;
  typedef logic [7:0]  cy_t;
  typedef logic [15:0] canvas_addr_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LINE_SETUP = 2'd1,
    LINE_STEP  = 2'd2,
    CLEARING   = 2'd3
  } stroke_state_t;

  typedef struct packed {
    cx_t     x;
    cy_t     y;
    colour_t colour;
    logic    pen;
  } point_t;

  // CANVAS_W is a constant, so the multiply folds into shifts and adds.
  function automatic canvas_addr_t canvas_addr(input cx_t cx, input cy_t cy);
    return canvas_addr_t'(cy) * canvas_addr_t'(CANVAS_W) + canvas_addr_t'(cx);
  endfunction

endpackage

// File: rtl/stroke_drawer_if.sv
// Point input and canvas write bus of the stroke drawer; the master side feeds
// points and observes the canvas writes, the slave side is the drawer itself.
interface stroke_drawer_if;
  import lightboard_pkg::*;

  logic [10:0]  x_com_in;
  logic [9:0]   y_com_in;
  logic         valid_com_in;
  logic         pen_down_in;
  colour_t      colour_in;
  logic         clear_in;
  canvas_addr_t canvas_addr_out;
  colour_t      canvas_data_out;
  logic         canvas_we_out;
  logic         busy_out;

  modport master (
    output x_com_in, y_com_in, valid_com_in, pen_down_in, colour_in, clear_in,
    input  canvas_addr_out, canvas_data_out, canvas_we_out, busy_out
  );

  modport slave (
    input  x_com_in, y_com_in, valid_com_in, pen_down_in, colour_in, clear_in,
    output canvas_addr_out, canvas_data_out, canvas_we_out, busy_out
  );

endinterface

// File: rtl/stroke_drawer_stepper.sv
// Bresenham line stepper on canvas coordinates: loaded with both endpoints,
// then advances one pixel per step and flags when the endpoint is reached.
module bresenham_stepper
  import lightboard_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic step_i,
  input  cx_t  x0_i,
  input  cy_t  y0_i,
  input  cx_t  x1_i,
  input  cy_t  y1_i,
  output cx_t  x_o,
  output cy_t  y_o,
  output cx_t  nx_o,
  output cy_t  ny_o,
  output logic done_o
);

  cx_t                x_q;
  cy_t                y_q;
  logic signed [10:0] err_q;
  logic signed [10:0] dx_q;
  logic signed [10:0] dy_q;
  logic               sx_q;
  logic               sy_q;

  cx_t                adx_d;
  cy_t                ady_d;
  logic signed [10:0] dx_d;
  logic signed [10:0] dy_d;
  logic signed [10:0] err_d;
  logic signed [10:0] err_step_d;
  logic signed [11:0] e2;
  logic signed [11:0] dx12;
  logic signed [11:0] dy12;
  logic               mv_x;
  logic               mv_y;

  // Line setup terms and the next point of the current line.
  always_comb begin
    adx_d      = (x1_i >= x0_i) ? (x1_i - x0_i) : (x0_i - x1_i);
    ady_d      = (y1_i >= y0_i) ? (y1_i - y0_i) : (y0_i - y1_i);
    dx_d       = $signed({2'b00, adx_d});
    dy_d       = 11'sd0 - $signed({3'b000, ady_d});
    err_d      = dx_d + dy_d;
    e2         = {err_q, 1'b0};
    dx12       = {dx_q[10], dx_q};
    dy12       = {dy_q[10], dy_q};
    mv_x       = (e2 >= dy12);
    mv_y       = (e2 <= dx12);
    // Both axis corrections use the pre-update error, so they may combine.
    err_step_d = err_q + (mv_x ? dy_q : 11'sd0) + (mv_y ? dx_q : 11'sd0);
    nx_o       = mv_x ? (sx_q ? (x_q - 9'd1) : (x_q + 9'd1)) : x_q;
    ny_o       = mv_y ? (sy_q ? (y_q - 8'd1) : (y_q + 8'd1)) : y_q;
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign done_o = (x_q == x1_i) && (y_q == y1_i);

  // Stepper state: load the start point and slopes, or advance one pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= 9'd0;
      y_q   <= 8'd0;
      err_q <= 11'sd0;
      dx_q  <= 11'sd0;
      dy_q  <= 11'sd0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
    end else if (load_i) begin
      x_q   <= x0_i;
      y_q   <= y0_i;
      err_q <= err_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      sx_q  <= (x1_i < x0_i);
      sy_q  <= (y1_i < y0_i);
    end else if (step_i) begin
      x_q   <= nx_o;
      y_q   <= ny_o;
      err_q <= err_step_d;
    end
  end

endmodule

// File: rtl/stroke_drawer.sv
// Turns successive centre-of-mass points into connected Bresenham strokes on
// the reduced-resolution canvas, one BRAM pixel write per cycle, plus clear.
module stroke_drawer
  import lightboard_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  stroke_drawer_if.slave bus
);

  stroke_state_t state_q;
  point_t        tgt_q;
  point_t        pend_q;
  logic          pend_valid_q;
  cx_t           prev_x_q;
  cy_t           prev_y_q;
  logic          prev_valid_q;
  canvas_addr_t  clr_cnt_q;
  canvas_addr_t  addr_q;
  colour_t       data_q;
  logic          we_q;
  logic          busy_q;

  point_t live_pt;
  logic   live_ok;
  cx_t    start_x;
  cy_t    start_y;
  cx_t    st_x;
  cy_t    st_y;
  cx_t    st_nx;
  cy_t    st_ny;
  logic   st_done;
  logic   st_load;
  logic   st_step;

  // Live point converted to canvas coordinates with its range qualification.
  always_comb begin
    live_pt.x      = cx_t'(bus.x_com_in >> CANVAS_SHIFT);
    live_pt.y      = cy_t'(bus.y_com_in >> CANVAS_SHIFT);
    live_pt.colour = bus.colour_in;
    live_pt.pen    = bus.pen_down_in;
    live_ok        = bus.valid_com_in
                     && (bus.x_com_in < 11'(H_PIXELS))
                     && (bus.y_com_in < 10'(V_PIXELS));
  end

  // A lifted pen or a broken stroke starts the line at the new point itself.
  assign start_x = (prev_valid_q && tgt_q.pen) ? prev_x_q : tgt_q.x;
  assign start_y = (prev_valid_q && tgt_q.pen) ? prev_y_q : tgt_q.y;
  assign st_load = (state_q == LINE_SETUP) && !bus.clear_in;
  assign st_step = (state_q == LINE_STEP) && !bus.clear_in && !st_done;

  bresenham_stepper u_stepper (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .load_i (st_load),
    .step_i (st_step),
    .x0_i   (start_x),
    .y0_i   (start_y),
    .x1_i   (tgt_q.x),
    .y1_i   (tgt_q.y),
    .x_o    (st_x),
    .y_o    (st_y),
    .nx_o   (st_nx),
    .ny_o   (st_ny),
    .done_o (st_done)
  );

  // Control FSM with pending point, clear sweep and registered write port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      prev_x_q     <= 9'd0;
      prev_y_q     <= 8'd0;
      prev_valid_q <= 1'b0;
      clr_cnt_q    <= 16'd0;
      addr_q       <= 16'd0;
      data_q       <= 2'd0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Points arriving while busy wait here; later branches may discard them.
      if ((state_q != IDLE) && live_ok) begin
        pend_q       <= live_pt;
        pend_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.clear_in) begin
            state_q      <= CLEARING;
            clr_cnt_q    <= 16'd0;
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b1;
          end else if (live_ok) begin
            tgt_q        <= live_pt;
            pend_valid_q <= 1'b0;
            state_q      <= LINE_SETUP;
            busy_q       <= 1'b1;
          end else if (pend_valid_q) begin
            tgt_q        <= pend_q;
            pend_valid_q <= 1'b0;
            state_q      <= LINE_SETUP;
            busy_q       <= 1'b1;
          end
        end
        LINE_SETUP: begin
          if (bus.clear_in) begin
            state_q      <= CLEARING;
            clr_cnt_q    <= 16'd0;
            pend_valid_q <= 1'b0;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= canvas_addr(start_x, start_y);
            data_q  <= tgt_q.colour;
            state_q <= LINE_STEP;
          end
        end
        LINE_STEP: begin
          if (bus.clear_in) begin
            state_q      <= CLEARING;
            clr_cnt_q    <= 16'd0;
            pend_valid_q <= 1'b0;
          end else if (st_done) begin
            prev_x_q     <= st_x;
            prev_y_q     <= st_y;
            prev_valid_q <= tgt_q.pen;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= canvas_addr(st_nx, st_ny);
            data_q <= tgt_q.colour;
          end
        end
        CLEARING: begin
          if (clr_cnt_q == canvas_addr_t'(CANVAS_PIXELS)) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            pend_valid_q <= 1'b0;
          end else begin
            we_q      <= 1'b1;
            addr_q    <= clr_cnt_q;
            data_q    <= 2'd0;
            clr_cnt_q <= clr_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.canvas_addr_out = addr_q;
  assign bus.canvas_data_out = data_q;
  assign bus.canvas_we_out   = we_q;
  assign bus.busy_out        = busy_q;

endmodule
